// File: rtl/tour_cmd_seq.sv
// Knight's tour command sequencer: each one-hot L move becomes a vertical command,
// then a horizontal command with fanfare. When idle, UART commands pass straight through.
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_err
);

  // state  | meaning
  // IDLE   | UART pass-through, waiting for start_tour
  // VERT   | vertical command offered to cmd_proc
  // WAIT_V | vertical command executing, waiting for send_resp
  // HORZ   | horizontal (fanfare) command offered to cmd_proc
  // WAIT_H | horizontal command executing, waiting for send_resp
  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  localparam logic [7:0] RESP_ACK  = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_mv_indx;
  logic [15:0]      w_vert_cmd;
  logic [15:0]      w_horz_cmd;
  logic             w_move_ok;
  logic             w_last;

  assign w_last    = (r_mv_indx == IDX_W'(NUM_MOVES - 1));
  assign mv_indx   = r_mv_indx;
  assign tour_busy = (r_state != IDLE);

  // Any encoding that is not exactly one-hot falls to the default and flags an error.
  always_comb begin
    w_move_ok  = 1'b1;
    w_vert_cmd = 16'h0000;
    w_horz_cmd = 16'h0000;
    case (move)
      8'h01: begin w_vert_cmd = 16'h4002; w_horz_cmd = 16'h5BF1; end
      8'h02: begin w_vert_cmd = 16'h4002; w_horz_cmd = 16'h53F1; end
      8'h04: begin w_vert_cmd = 16'h4001; w_horz_cmd = 16'h53F2; end
      8'h08: begin w_vert_cmd = 16'h47F1; w_horz_cmd = 16'h53F2; end
      8'h10: begin w_vert_cmd = 16'h47F2; w_horz_cmd = 16'h53F1; end
      8'h20: begin w_vert_cmd = 16'h47F2; w_horz_cmd = 16'h5BF1; end
      8'h40: begin w_vert_cmd = 16'h47F1; w_horz_cmd = 16'h5BF2; end
      8'h80: begin w_vert_cmd = 16'h4001; w_horz_cmd = 16'h5BF2; end
      default: w_move_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mv_indx <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_tour)
        r_mv_indx <= '0;
      else if (r_state == WAIT_H && send_resp && !w_last)
        r_mv_indx <= r_mv_indx + 1'b1;
    end
  end

  always_comb begin
    w_next           = r_state;
    cmd              = 16'h0000;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_ACK;
    tour_err         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) w_next = VERT;
      end
      VERT: begin
        if (!w_move_ok) begin
          tour_err = 1'b1;
          w_next   = IDLE;
        end else begin
          cmd     = w_vert_cmd;
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) w_next = WAIT_V;
        end
      end
      WAIT_V: begin
        if (send_resp) w_next = HORZ;
      end
      HORZ: begin
        cmd     = w_horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) w_next = WAIT_H;
      end
      WAIT_H: begin
        // Only the horizontal leg of the final move reports completion to the remote.
        resp = w_last ? RESP_DONE : RESP_ACK;
        if (send_resp) w_next = w_last ? IDLE : VERT;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: pass-through, single move, full tour with UART
// isolation, invalid move abort, and reset mid-tour with spurious handshakes.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_busy;
  logic        tour_err;

  int total = 0;
  int bad   = 0;
  int n_cmds;
  bit iso_bad;

  logic [7:0]  move_tab [0:31];
  logic [15:0] vexp [0:7];
  logic [15:0] hexp [0:7];

  tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .tour_busy(tour_busy), .tour_err(tour_err)
  );

  always #5 clk = ~clk;

  // Solver storage: combinational lookup by the index the DUT is playing.
  assign move = move_tab[mv_indx];

  always @(negedge clk)
    if (tour_busy && (clr_cmd_rdy_UART || (cmd_rdy && cmd === cmd_UART))) iso_bad = 1'b1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int bitpos(input logic [7:0] m);
    int p = 0;
    for (int k = 0; k < 8; k++) if (m[k]) p = k;
    return p;
  endfunction

  task automatic pulse_start();
    start_tour = 1'b1; tick(); start_tour = 1'b0;
  endtask

  task automatic finish_move();
    send_resp = 1'b1; tick(); send_resp = 1'b0;
  endtask

  // Entered in VERT; leaves the DUT in WAIT_H with the final send_resp still owed.
  task automatic do_move(input int i, input bit last, input bit spur);
    int b;
    b = bitpos(move_tab[i]);
    chk("vert_rdy", 32'(cmd_rdy), 32'd1);
    chk("vert_cmd", 32'(cmd), 32'(vexp[b]));
    chk("vert_idx", 32'(mv_indx), 32'(i));
    n_cmds++;
    if (spur) begin
      send_resp = 1'b1; start_tour = 1'b1; tick(); send_resp = 1'b0; start_tour = 1'b0;
      chk("spur_vert_rdy", 32'(cmd_rdy), 32'd1);
      chk("spur_vert_cmd", 32'(cmd), 32'(vexp[b]));
      chk("spur_vert_idx", 32'(mv_indx), 32'(i));
    end
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("waitv_rdy", 32'(cmd_rdy), 32'd0);
    repeat ($urandom_range(3, 0)) tick();
    if (spur) begin
      clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
      chk("spur_waitv_rdy", 32'(cmd_rdy), 32'd0);
    end
    finish_move();
    chk("horz_rdy", 32'(cmd_rdy), 32'd1);
    chk("horz_cmd", 32'(cmd), 32'(hexp[b]));
    n_cmds++;
    if (spur) begin
      finish_move();
      chk("spur_horz_cmd", 32'(cmd), 32'(hexp[b]));
    end
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("waith_rdy", 32'(cmd_rdy), 32'd0);
    chk("waith_resp", 32'(resp), last ? 32'hA5 : 32'h5A);
    repeat ($urandom_range(3, 0)) tick();
  endtask

  initial begin
    vexp[0] = 16'h4002; hexp[0] = 16'h5BF1;
    vexp[1] = 16'h4002; hexp[1] = 16'h53F1;
    vexp[2] = 16'h4001; hexp[2] = 16'h53F2;
    vexp[3] = 16'h47F1; hexp[3] = 16'h53F2;
    vexp[4] = 16'h47F2; hexp[4] = 16'h53F1;
    vexp[5] = 16'h47F2; hexp[5] = 16'h5BF1;
    vexp[6] = 16'h47F1; hexp[6] = 16'h5BF2;
    vexp[7] = 16'h4001; hexp[7] = 16'h5BF2;
    for (int i = 0; i < 32; i++) move_tab[i] = 8'h01;
    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; iso_bad = 1'b0; n_cmds = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_idx", 32'(mv_indx), 32'd0);
    chk("rst_busy", 32'(tour_busy), 32'd0);
    chk("rst_err", 32'(tour_err), 32'd0);
    chk("rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp", 32'(resp), 32'hA5);

    // pass-through
    cmd_UART = 16'h47F1; cmd_rdy_UART = 1'b1; #1;
    chk("pt_cmd", 32'(cmd), 32'h47F1);
    chk("pt_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1; #1;
    chk("pt_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    chk("pt_busy", 32'(tour_busy), 32'd0);
    tick(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
    chk("pt_clr_off", 32'(clr_cmd_rdy_UART), 32'd0);

    // single move, start_tour wins over a pending UART command
    move_tab[0] = 8'h20;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    pulse_start();
    chk("sm_busy", 32'(tour_busy), 32'd1);
    do_move(0, 1'b0, 1'b0);
    finish_move();
    chk("sm_idx", 32'(mv_indx), 32'd1);
    chk("sm_resp", 32'(resp), 32'h5A);
    chk("sm_rdy2", 32'(cmd_rdy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("sm_rst_idx", 32'(mv_indx), 32'd0);
    chk("sm_rst_busy", 32'(tour_busy), 32'd0);

    // full tour with UART command arriving mid-tour
    for (int i = 0; i < 24; i++) move_tab[i] = 8'h01 << $urandom_range(7, 0);
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h1234; n_cmds = 0; iso_bad = 1'b0;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      if (i == 5) cmd_rdy_UART = 1'b1;
      do_move(i, i == 23, 1'b0);
      finish_move();
    end
    chk("ft_ncmds", 32'(n_cmds), 32'd48);
    chk("ft_busy", 32'(tour_busy), 32'd0);
    chk("ft_resp", 32'(resp), 32'hA5);
    chk("ft_iso", 32'(iso_bad), 32'd0);
    chk("ft_uart_cmd", 32'(cmd), 32'h1234);
    chk("ft_uart_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1; #1;
    chk("ft_uart_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    tick(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // invalid move at index 3
    for (int i = 0; i < 3; i++) move_tab[i] = 8'h01 << $urandom_range(7, 0);
    move_tab[3] = 8'h00;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      do_move(i, 1'b0, 1'b0);
      finish_move();
    end
    chk("inv_err", 32'(tour_err), 32'd1);
    chk("inv_rdy", 32'(cmd_rdy), 32'd0);
    chk("inv_idx", 32'(mv_indx), 32'd3);
    tick();
    chk("inv_err_off", 32'(tour_err), 32'd0);
    chk("inv_busy", 32'(tour_busy), 32'd0);
    chk("inv_idx_hold", 32'(mv_indx), 32'd3);
    chk("inv_rdy2", 32'(cmd_rdy), 32'd0);

    // reset mid-tour at index 10, spurious handshakes along the way
    for (int i = 0; i < 24; i++) move_tab[i] = 8'h01 << $urandom_range(7, 0);
    move_tab[3] = 8'h11;
    move_tab[3] = 8'h08;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      do_move(i, 1'b0, i == 0);
      finish_move();
    end
    do_move(10, 1'b0, 1'b0);
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("rmt_spur_idx", 32'(mv_indx), 32'd10);
    chk("rmt_spur_busy", 32'(tour_busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rmt_idx", 32'(mv_indx), 32'd0);
    chk("rmt_rdy", 32'(cmd_rdy), 32'd0);
    chk("rmt_busy", 32'(tour_busy), 32'd0);
    finish_move();
    chk("rmt_idle_sr", 32'(tour_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
